conv_mac_stream: RTL and testbench

// - Streaming convolution MAC. Accumulates signed window products over FILTER_SIZE^2 taps
//   and NUM_CH input channels, one output pixel at a time. Beats carry LANES products.
// - Applies optional ReLU and saturation, then emits one result per pixel in raster order

---
 rtl/conv_mac_stream.sv | 185 ++++++++++++++++++
 tb/tb_conv_mac_stream.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_stream.sv
// Streaming convolution MAC: sums LANES signed products per beat over BEATS beats per pixel,
// then applies optional ReLU and saturation and presents one raster-tagged result per pixel.
module conv_mac_stream #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int FILTER_SIZE   = 3,
    parameter int OFMAP_SIZE    = 4,
    parameter int NUM_CH        = 4,
    parameter int LANES         = 3,
    parameter int OUT_W         = 16,
    localparam int PW    = 2 * IP_DATA_WIDTH,
    localparam int TAPS  = FILTER_SIZE * FILTER_SIZE,
    localparam int ACC_W = PW + $clog2(TAPS * NUM_CH) + 1,
    localparam int BEATS = TAPS / LANES * NUM_CH,
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int RC_W  = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       relu_en,
    input  logic                       prod_vld,
    output logic                       prod_rdy,
    input  logic [LANES-1:0][PW-1:0]   prod_data,
    output logic                       res_vld,
    input  logic                       res_rdy,
    output logic [OUT_W-1:0]           res_data,
    output logic [RC_W-1:0]            res_row,
    output logic [RC_W-1:0]            res_col,
    output logic                       frame_done,
    output logic                       ovf_sticky
);

    if (TAPS % LANES != 0) begin : g_bad_lanes
        $error("conv_mac_stream: LANES must divide FILTER_SIZE^2");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic                      relu_q, relu_d;
    logic                      res_vld_q, res_vld_d;
    logic [OUT_W-1:0]          res_data_q, res_data_d;
    logic [RC_W-1:0]           row_q, row_d;
    logic [RC_W-1:0]           col_q, col_d;
    logic                      frame_done_q, frame_done_d;
    logic                      ovf_q, ovf_d;

    logic signed [ACC_W-1:0]   lane_ext [LANES];
    logic signed [ACC_W-1:0]   beat_sum;
    logic signed [ACC_W-1:0]   total;
    logic [OUT_W-1:0]          sat_data;
    logic                      sat_clip;
    logic                      first_beat, last_beat, relu_eff;
    logic                      beat_fire, res_fire, last_pixel;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_ext[gi] = ACC_W'($signed(prod_data[gi]));
    end

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_sum = beat_sum + lane_ext[i];
        end
    end

    // Holding a result keeps the input stalled unless the result leaves this same cycle.
    assign prod_rdy   = rst_n && ((state_q != S_HOLD) || res_rdy);
    assign beat_fire  = prod_vld && prod_rdy;
    assign res_fire   = res_vld_q && res_rdy;
    assign first_beat = (state_q != S_ACCUM);
    assign last_beat  = (beat_cnt_q == CNT_W'(BEATS - 1));
    assign relu_eff   = first_beat ? relu_en : relu_q;
    assign total      = (first_beat ? '0 : acc_q) + beat_sum;
    assign last_pixel = (row_q == RC_W'(OFMAP_SIZE - 1)) && (col_q == RC_W'(OFMAP_SIZE - 1));

    always_comb begin
        sat_clip = 1'b0;
        sat_data = total[OUT_W-1:0];
        if (relu_eff && total[ACC_W-1]) begin
            sat_data = '0;
        end else if (total > SAT_MAX) begin
            sat_data = SAT_MAX[OUT_W-1:0];
            sat_clip = 1'b1;
        end else if (total < SAT_MIN) begin
            sat_data = SAT_MIN[OUT_W-1:0];
            sat_clip = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        beat_cnt_d   = beat_cnt_q;
        relu_d       = relu_q;
        res_vld_d    = res_vld_q;
        res_data_d   = res_data_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_done_d = 1'b0;
        ovf_d        = ovf_q;

        if (res_fire) begin
            res_vld_d = 1'b0;
            state_d   = S_IDLE;
            if (col_q == RC_W'(OFMAP_SIZE - 1)) begin
                col_d = '0;
                row_d = (row_q == RC_W'(OFMAP_SIZE - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            frame_done_d = last_pixel;
        end

        // A beat in HOLD implies the result left this cycle, so it safely starts the next pixel.
        if (beat_fire) begin
            if (first_beat) begin
                relu_d = relu_en;
            end
            if (last_beat) begin
                state_d    = S_HOLD;
                beat_cnt_d = '0;
                res_vld_d  = 1'b1;
                res_data_d = sat_data;
                ovf_d      = ovf_q | sat_clip;
            end else begin
                state_d    = S_ACCUM;
                acc_d      = total;
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        if (clear) begin
            state_d      = S_IDLE;
            acc_d        = '0;
            beat_cnt_d   = '0;
            relu_d       = 1'b0;
            res_vld_d    = 1'b0;
            res_data_d   = '0;
            row_d        = '0;
            col_d        = '0;
            frame_done_d = 1'b0;
            ovf_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            beat_cnt_q   <= '0;
            relu_q       <= 1'b0;
            res_vld_q    <= 1'b0;
            res_data_q   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            beat_cnt_q   <= beat_cnt_d;
            relu_q       <= relu_d;
            res_vld_q    <= res_vld_d;
            res_data_q   <= res_data_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign res_vld    = res_vld_q;
    assign res_data   = res_data_q;
    assign res_row    = row_q;
    assign res_col    = col_q;
    assign frame_done = frame_done_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_conv_mac_stream.sv
// Scoreboard bench for conv_mac_stream: stimulus pushes expected pixels, a monitor pops on accept.
module tb_conv_mac_stream;
    localparam int LANES = 3;
    localparam int BEATS = 12;
    localparam int OFMAP = 4;

    logic                    clk = 1'b0;
    logic                    rst_n, clear, relu_en, prod_vld, prod_rdy;
    logic                    res_vld, res_rdy, frame_done, ovf_sticky;
    logic [LANES-1:0][15:0]  prod_data;
    logic [15:0]             res_data;
    logic [1:0]              res_row, res_col;

    typedef struct {
        int data;
        int row;
        int col;
    } exp_t;

    exp_t sb_q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   exp_row  = 0;
    int   exp_col  = 0;
    int   fd_count = 0;

    conv_mac_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .relu_en    (relu_en),
        .prod_vld   (prod_vld),
        .prod_rdy   (prod_rdy),
        .prod_data  (prod_data),
        .res_vld    (res_vld),
        .res_rdy    (res_rdy),
        .res_data   (res_data),
        .res_row    (res_row),
        .res_col    (res_col),
        .frame_done (frame_done),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: samples 1 ns before each rising edge.
    initial begin : monitor
        bit   prev_last;
        exp_t e;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && frame_done) begin
                fd_count++;
                chk("frame_done_follows_last_pixel", int'(prev_last), 1);
            end
            prev_last = 1'b0;
            if (rst_n && res_vld && res_rdy) begin
                chk("scoreboard_has_entry", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("res_data", int'($signed(res_data)), e.data);
                    chk("res_row", int'(res_row), e.row);
                    chk("res_col", int'(res_col), e.col);
                    $display("[TB] result %0d at (%0d,%0d)", int'($signed(res_data)), res_row, res_col);
                    prev_last = (e.row == OFMAP - 1) && (e.col == OFMAP - 1);
                end
            end
        end
    end

    // Call at a falling edge; returns at the falling edge after the beat transfers.
    task automatic send_beat(input int a, input int b, input int c, input bit relu);
        bit done;
        done = 1'b0;
        prod_data[0] = 16'(a);
        prod_data[1] = 16'(b);
        prod_data[2] = 16'(c);
        relu_en  = relu;
        prod_vld = 1'b1;
        for (int g = 0; g < 100 && !done; g++) begin
            #4;
            if (prod_rdy) done = 1'b1;
            @(negedge clk);
        end
        prod_vld = 1'b0;
        if (!done) chk("beat_accept_timeout", int'(done), 1);
    endtask

    task automatic push_exp(input int data);
        exp_t e;
        e.data = data;
        e.row  = exp_row;
        e.col  = exp_col;
        sb_q.push_back(e);
        if (exp_col == OFMAP - 1) begin
            exp_col = 0;
            exp_row = (exp_row == OFMAP - 1) ? 0 : exp_row + 1;
        end else begin
            exp_col++;
        end
    endtask

    task automatic send_const_pixel(input int v, input int exp);
        push_exp(exp);
        for (int b = 0; b < BEATS; b++) send_beat(v, v, v, 1'b0);
    endtask

    // Alternating +/-100 products; total is -300 (relu only presented on the first beat).
    task automatic send_t2_pixel(input bit relu);
        for (int k = 0; k < BEATS - 1; k++) begin
            if (k % 2 == 0) send_beat(-100, 100, -100, (k == 0) ? relu : !relu);
            else            send_beat(100, -100, 100, !relu);
        end
        send_beat(-100, -100, 0, !relu);
    endtask

    task automatic drain();
        for (int g = 0; g < 500 && sb_q.size() != 0; g++) @(negedge clk);
        if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        rst_n = 1'b0; clear = 1'b0; relu_en = 1'b0; prod_vld = 1'b0;
        prod_data = '0; res_rdy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_res_vld", int'(res_vld), 0);
        chk("rst_prod_rdy", int'(prod_rdy), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_row_col", int'({res_row, res_col}), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_ovf", int'(ovf_sticky), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("prod_rdy_after_reset", int'(prod_rdy), 1);
        @(negedge clk);

        // T1: full frame of all-ones products -> 36 per pixel
        for (int p = 0; p < OFMAP * OFMAP; p++) send_const_pixel(1, 36);
        drain();
        chk("t1_frame_done_count", fd_count, 1);

        // T2: sum -300 with and without ReLU
        push_exp(0);
        send_t2_pixel(1'b1);
        push_exp(-300);
        send_t2_pixel(1'b0);
        drain();
        chk("t2_ovf_clear", int'(ovf_sticky), 0);

        // T3: saturation both ways
        send_const_pixel(32767, 32767);
        drain();
        chk("t3_ovf_set", int'(ovf_sticky), 1);
        send_const_pixel(-32768, -32768);
        drain();
        chk("t3_ovf_still_set", int'(ovf_sticky), 1);

        // T4: backpressure with the next pixel pending
        res_rdy = 1'b0;
        push_exp(108);
        for (int b = 0; b < BEATS; b++) send_beat(2, 3, 4, 1'b0);
        push_exp(60);
        fork
            begin
                for (int b = 0; b < BEATS; b++) send_beat(1, -1, 5, 1'b0);
            end
            begin
                for (int c = 0; c < 5; c++) begin
                    #4;
                    chk("t4_prod_rdy_low", int'(prod_rdy), 0);
                    chk("t4_res_vld_held", int'(res_vld), 1);
                    chk("t4_res_data_stable", int'($signed(res_data)), 108);
                    chk("t4_row_stable", int'(res_row), 1);
                    chk("t4_col_stable", int'(res_col), 0);
                    @(negedge clk);
                end
                res_rdy = 1'b1;
                #4;
                chk("t4_release_prod_rdy", int'(prod_rdy), 1);
                chk("t4_release_res_vld", int'(res_vld), 1);
            end
        join
        drain();

        // T5: clear mid-pixel, then one pixel of 2s
        for (int b = 0; b < 5; b++) send_beat(1, 1, 1, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("t5_res_vld_after_clear", int'(res_vld), 0);
        chk("t5_ovf_after_clear", int'(ovf_sticky), 0);
        chk("t5_row_col_after_clear", int'({res_row, res_col}), 0);
        @(negedge clk);
        exp_row = 0;
        exp_col = 0;
        send_const_pixel(2, 72);
        drain();
        chk("t5_no_frame_done", fd_count, 1);

        // T6: asynchronous reset with a held result, then mid-pixel, then recovery
        res_rdy = 1'b0;
        send_const_pixel(1, 36);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_res_vld_async", int'(res_vld), 0);
        chk("t6_res_data_async", int'(res_data), 0);
        chk("t6_col_async", int'(res_col), 0);
        chk("t6_prod_rdy_async", int'(prod_rdy), 0);
        sb_q.delete();
        exp_row = 0;
        exp_col = 0;
        @(negedge clk);
        rst_n = 1'b1;
        res_rdy = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 5; b++) send_beat(3, 3, 3, 1'b0);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int p = 0; p < OFMAP * OFMAP; p++) send_const_pixel(1, 36);
        drain();
        chk("t6_frame_done_count", fd_count, 2);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
